// File: rtl/spi_shift_ctrl_if.sv
// Control-side bus of the SPI shift engine.
// Carries configuration and TX word in, RX word and status out.
interface spi_shift_ctrl_if #(
  parameter int SPI_MAX_CHAR = 32,
  parameter int SPI_CNT_LEN  = 6
);

  logic                    i_go;
  logic [SPI_CNT_LEN-1:0]  i_len;
  logic                    i_lsb;
  logic                    i_tx_negedge;
  logic                    i_rx_negedge;
  logic [SPI_MAX_CHAR-1:0] i_tx_data;
  logic [SPI_MAX_CHAR-1:0] o_rx_data;
  logic                    o_done;
  logic                    o_tip;

  modport master (
    output i_go,
    output i_len,
    output i_lsb,
    output i_tx_negedge,
    output i_rx_negedge,
    output i_tx_data,
    input  o_rx_data,
    input  o_done,
    input  o_tip
  );

  modport slave (
    input  i_go,
    input  i_len,
    input  i_lsb,
    input  i_tx_negedge,
    input  i_rx_negedge,
    input  i_tx_data,
    output o_rx_data,
    output o_done,
    output o_tip
  );

endinterface

// File: rtl/spi_shift_ctrl.sv
// SPI bit-level shift engine: drives MOSI, samples MISO, counts bits
// and gates the SPI clock generator for exactly the programmed length.
module spi_shift_ctrl #(
  parameter int SPI_MAX_CHAR = 32,
  parameter int SPI_CNT_LEN  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  spi_shift_ctrl_if.slave   bus,
  input  logic              i_pos_edge,
  input  logic              i_neg_edge,
  input  logic              i_miso,
  output logic              o_clk_en,
  output logic              o_last_clk,
  output logic              o_mosi
);

  localparam int CW = SPI_CNT_LEN;
  localparam int DW = SPI_MAX_CHAR;
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] MAX_L = CW'(DW);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   len_q, len_d;
  logic            lsb_q, lsb_d;
  logic            tx_neg_q, tx_neg_d;
  logic            rx_neg_q, rx_neg_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic            mosi_q, mosi_d;
  logic            tip_q, tip_d;
  logic            clk_en_q, clk_en_d;
  logic            last_clk_q, last_clk_d;
  logic            done_q, done_d;

  logic [CW-1:0]   eff_len;
  logic            tx_ev;
  logic            rx_ev;

  // Data index of transmitted bit k for the given order and length.
  function automatic logic [IW-1:0] bit_idx(
    input logic          lsb,
    input logic [CW-1:0] len,
    input logic [CW-1:0] k
  );
    logic [CW-1:0] i;
    i = lsb ? k : (len - ONE - k);
    return IW'(i);
  endfunction

  // Effective length and the selected shift/sample strobes.
  always_comb begin
    eff_len = bus.i_len;
    if (bus.i_len == '0 || bus.i_len > MAX_L) begin
      eff_len = MAX_L;
    end
    tx_ev = tx_neg_q ? i_neg_edge : i_pos_edge;
    rx_ev = rx_neg_q ? i_neg_edge : i_pos_edge;
  end

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    lsb_d      = lsb_q;
    tx_neg_d   = tx_neg_q;
    rx_neg_d   = rx_neg_q;
    tx_data_d  = tx_data_q;
    rx_data_d  = rx_data_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    mosi_d     = mosi_q;
    tip_d      = tip_q;
    clk_en_d   = clk_en_q;
    last_clk_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tip_d    = 1'b0;
        clk_en_d = 1'b0;
        if (bus.i_go) begin
          len_d     = eff_len;
          lsb_d     = bus.i_lsb;
          tx_neg_d  = bus.i_tx_negedge;
          rx_neg_d  = bus.i_rx_negedge;
          tx_data_d = bus.i_tx_data;
          mosi_d    = bus.i_tx_data[
            bit_idx(bus.i_lsb, eff_len, '0)];
          tx_cnt_d  = ONE;
          rx_cnt_d  = '0;
          rx_data_d = '0;
          tip_d     = 1'b1;
          clk_en_d  = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (tx_ev && tx_cnt_q < len_q) begin
          mosi_d   = tx_data_q[
            bit_idx(lsb_q, len_q, tx_cnt_q)];
          tx_cnt_d = tx_cnt_q + ONE;
        end
        if (rx_ev) begin
          rx_data_d[bit_idx(lsb_q, len_q, rx_cnt_q)]
            = i_miso;
          rx_cnt_d = rx_cnt_q + ONE;
          if (rx_cnt_q + ONE == len_q) begin
            state_d    = DONE;
            tip_d      = 1'b0;
            clk_en_d   = 1'b0;
            done_d     = 1'b1;
            last_clk_d = 1'b1;
          end
        end
      end

      DONE: begin
        tip_d    = 1'b0;
        clk_en_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        tip_d    = 1'b0;
        clk_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      lsb_q      <= 1'b0;
      tx_neg_q   <= 1'b0;
      rx_neg_q   <= 1'b0;
      tx_data_q  <= '0;
      rx_data_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      mosi_q     <= 1'b0;
      tip_q      <= 1'b0;
      clk_en_q   <= 1'b0;
      last_clk_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      lsb_q      <= lsb_d;
      tx_neg_q   <= tx_neg_d;
      rx_neg_q   <= rx_neg_d;
      tx_data_q  <= tx_data_d;
      rx_data_q  <= rx_data_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      mosi_q     <= mosi_d;
      tip_q      <= tip_d;
      clk_en_q   <= clk_en_d;
      last_clk_q <= last_clk_d;
      done_q     <= done_d;
    end
  end

  assign o_mosi        = mosi_q;
  assign o_clk_en      = clk_en_q;
  assign o_last_clk    = last_clk_q;
  assign bus.o_tip     = tip_q;
  assign bus.o_done    = done_q;
  assign bus.o_rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// Directed testbench for spi_shift_ctrl.
// Hand-computed vectors checked with immediate assertions.
module tb_spi_shift_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pos_e;
  logic neg_e;
  logic miso;
  logic loop_en;
  logic miso_drv;
  logic clk_en;
  logic last_clk;
  logic mosi;

  spi_shift_ctrl_if #(
    .SPI_MAX_CHAR(32),
    .SPI_CNT_LEN(6)
  ) bus ();

  assign miso = loop_en ? mosi : miso_drv;

  spi_shift_ctrl #(
    .SPI_MAX_CHAR(32),
    .SPI_CNT_LEN(6)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus.slave),
    .i_pos_edge (pos_e),
    .i_neg_edge (neg_e),
    .i_miso     (miso),
    .o_clk_en   (clk_en),
    .o_last_clk (last_clk),
    .o_mosi     (mosi)
  );

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  task automatic tick;
    @(posedge clk);
    #1;
    if (bus.o_done) done_cnt++;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic edge_p(input logic p, input logic n);
    pos_e = p;
    neg_e = n;
    tick();
    pos_e = 1'b0;
    neg_e = 1'b0;
  endtask

  task automatic start(input logic [5:0]  len,
                       input logic        lsb,
                       input logic        txn,
                       input logic        rxn,
                       input logic [31:0] data);
    bus.i_len        = len;
    bus.i_lsb        = lsb;
    bus.i_tx_negedge = txn;
    bus.i_rx_negedge = rxn;
    bus.i_tx_data    = data;
    bus.i_go         = 1'b1;
    tick();
    bus.i_go         = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},
        {27'd0, mosi, bus.o_tip, clk_en,
         last_clk, bus.o_done}, 32'd0);
    chk({tag, "_rx"}, bus.o_rx_data, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] pat;
    logic [3:0] q;

    rst_n            = 1'b0;
    pos_e            = 1'b0;
    neg_e            = 1'b0;
    loop_en          = 1'b1;
    miso_drv         = 1'b0;
    bus.i_go         = 1'b0;
    bus.i_len        = '0;
    bus.i_lsb        = 1'b0;
    bus.i_tx_negedge = 1'b0;
    bus.i_rx_negedge = 1'b0;
    bus.i_tx_data    = '0;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Reset in the middle of an 8-bit transfer.
    start(6'd8, 1'b0, 1'b1, 1'b0, 32'hA5);
    chk("t1_tip", {31'd0, bus.o_tip}, 32'd1);
    chk("t1_clk_en", {31'd0, clk_en}, 32'd1);
    chk("t1_mosi0", {31'd0, mosi}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      edge_p(1'b1, 1'b0);
      edge_p(1'b0, 1'b1);
    end
    chk("t1_rx3", bus.o_rx_data, 32'hA0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_zero("t1_rst");
    for (int k = 0; k < 2; k++) begin
      edge_p(1'b1, 1'b0);
      edge_p(1'b0, 1'b1);
    end
    chk("t1_idle",
        {30'd0, mosi, bus.o_tip}, 32'd0);

    // MSB-first loopback, TX on neg, RX on pos.
    b = 8'hA5;
    start(6'd8, 1'b0, 1'b1, 1'b0, 32'hA5);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_mosi%0d", k),
          {31'd0, mosi}, {31'd0, b[7-k]});
      edge_p(1'b1, 1'b0);
      if (k == 7) begin
        chk("t2_done", {31'd0, bus.o_done}, 32'd1);
        chk("t2_tip", {31'd0, bus.o_tip}, 32'd0);
        chk("t2_last", {31'd0, last_clk}, 32'd1);
        chk("t2_clk_en", {31'd0, clk_en}, 32'd0);
      end else begin
        chk($sformatf("t2_nodone%0d", k),
            {31'd0, bus.o_done}, 32'd0);
      end
      edge_p(1'b0, 1'b1);
    end
    chk("t2_done_end", {31'd0, bus.o_done}, 32'd0);
    chk("t2_rx", bus.o_rx_data, 32'h0000_00A5);

    // LSB-first with a fixed MISO pattern.
    loop_en = 1'b0;
    pat = 8'b1000_0011;
    start(6'd8, 1'b1, 1'b1, 1'b0, 32'hA5);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t3_mosi%0d", k),
          {31'd0, mosi}, {31'd0, b[k]});
      miso_drv = pat[k];
      edge_p(1'b1, 1'b0);
      edge_p(1'b0, 1'b1);
    end
    chk("t3_rx", bus.o_rx_data, 32'h83);
    loop_en = 1'b1;

    // Zero length means the full 32-bit word.
    done_cnt = 0;
    start(6'd0, 1'b0, 1'b1, 1'b0, 32'h8000_0001);
    chk("t4_mosi0", {31'd0, mosi}, 32'd1);
    for (int k = 0; k < 32; k++) begin
      edge_p(1'b1, 1'b0);
      edge_p(1'b0, 1'b1);
    end
    tick();
    tick();
    chk("t4_rx", bus.o_rx_data, 32'h8000_0001);
    chk("t4_done_cnt", done_cnt, 32'd1);

    // TX and RX on the same pos pulse, length 4.
    start(6'd4, 1'b0, 1'b0, 1'b0, 32'h9);
    for (int k = 0; k < 4; k++) edge_p(1'b1, 1'b0);
    chk("t5_done", {31'd0, bus.o_done}, 32'd1);
    tick();
    edge_p(1'b1, 1'b0);
    edge_p(1'b1, 1'b0);
    chk("t5_rx", bus.o_rx_data, 32'h9);
    chk("t5_tip", {31'd0, bus.o_tip}, 32'd0);
    chk("t5_done_end", {31'd0, bus.o_done}, 32'd0);
    chk("t5_mosi", {31'd0, mosi}, 32'd1);

    // go held high; mid-transfer config changes.
    q = 4'h6;
    bus.i_len        = 6'd4;
    bus.i_lsb        = 1'b0;
    bus.i_tx_negedge = 1'b1;
    bus.i_rx_negedge = 1'b0;
    bus.i_tx_data    = 32'h6;
    bus.i_go         = 1'b1;
    tick();
    bus.i_len     = 6'd8;
    bus.i_tx_data = 32'hFF;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6_mosi%0d", k),
          {31'd0, mosi}, {31'd0, q[3-k]});
      edge_p(1'b1, 1'b0);
      if (k < 3) edge_p(1'b0, 1'b1);
    end
    chk("t6_done", {31'd0, bus.o_done}, 32'd1);
    chk("t6_tip_done", {31'd0, bus.o_tip}, 32'd0);
    edge_p(1'b0, 1'b1);
    chk("t6_tip_idle", {31'd0, bus.o_tip}, 32'd0);
    chk("t6_rx", bus.o_rx_data, 32'h6);
    tick();
    chk("t6_restart", {31'd0, bus.o_tip}, 32'd1);
    chk("t6_rx_clr", bus.o_rx_data, 32'd0);
    chk("t6_mosi_new", {31'd0, mosi}, 32'd1);
    bus.i_go = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_zero("t6_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_shift_ctrl.md
Name: spi_shift_ctrl

Overview:
- Bit-level transfer engine sitting directly downstream of the SPI clock generator.
- Consumes the generator's single-cycle pos/neg edge pulses to drive MOSI, sample MISO and count bits.
- Drives the generator's enable and last-clock inputs, so SCLK runs only for exactly the programmed number of bits.
- Upstream: register/control block supplies go, length, bit order, edge selects and TX word; it reads back the RX word and done pulse.

Parameters:
- SPI_MAX_CHAR, 32, maximum character length in bits; width of i_tx_data/o_rx_data.
- SPI_CNT_LEN, 6, bit-counter width; must satisfy 2^SPI_CNT_LEN > SPI_MAX_CHAR.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  synchronous active-low reset.
- i_go  input  1  start pulse; sampled only in IDLE.
- i_len  input  SPI_CNT_LEN  character length in bits; 0 or any value >SPI_MAX_CHAR means SPI_MAX_CHAR.
- i_lsb  input  1  1 = LSB first, 0 = MSB first.
- i_tx_negedge  input  1  1 = MOSI updates on neg-edge pulses, 0 = on pos-edge pulses.
- i_rx_negedge  input  1  1 = MISO sampled on neg-edge pulses, 0 = on pos-edge pulses.
- i_tx_data  input  SPI_MAX_CHAR  word to transmit.
- i_pos_edge  input  1  SCLK rising-edge pulse from the clock generator.
- i_neg_edge  input  1  SCLK falling-edge pulse from the clock generator.
- i_miso  input  1  serial data in.
- o_clk_en  output  1  enable to the clock generator.
- o_last_clk  output  1  last-clock indication to the clock generator.
- o_mosi  output  1  serial data out.
- o_tip  output  1  transfer in progress.
- o_done  output  1  one-cycle completion pulse.
- o_rx_data  output  SPI_MAX_CHAR  received word.

Behaviour:
- Reset (synchronous, i_rst_n=0 at a rising i_clk edge) overrides everything, including mid-transfer.
  - State returns to IDLE.
  - All outputs go to 0: o_mosi, o_tip, o_clk_en, o_last_clk, o_done, o_rx_data.
  - Internal counters and the latched configuration are cleared.
- L = effective length, latched at go: i_len, or SPI_MAX_CHAR when i_len is 0 or >SPI_MAX_CHAR.
- Transmission order: bit k (k = 0..L-1) maps to data index k when lsb=1, and to index L-1-k when lsb=0. The same mapping applies to TX and RX.
- The latched copies of len, lsb, edge selects and tx_data are the only ones used while a transfer runs. Input changes mid-transfer have no effect.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - o_tip=0, o_clk_en=0. Edge pulses are ignored.
  - i_go=1 on a clock edge does the following, all visible the next cycle:
    - latch configuration;
    - o_mosi <= bit 0;
    - tx_cnt <= 1, rx_cnt <= 0;
    - o_rx_data <= 0;
    - state moves to SHIFT, with o_tip=1 and o_clk_en=1.
- SHIFT:
  - TX edge = selected pulse (i_neg_edge if tx_negedge, else i_pos_edge).
    - On a TX edge with tx_cnt<L: o_mosi <= bit tx_cnt, then tx_cnt increments.
    - A TX edge with tx_cnt=L is ignored; o_mosi holds.
  - RX edge = selected pulse, chosen by rx_negedge the same way.
    - On an RX edge: o_rx_data[index(rx_cnt)] <= i_miso, then rx_cnt increments.
  - TX and RX edges in the same cycle (same or different pulse) are both processed.
  - When an RX edge makes rx_cnt reach L, state moves to DONE on that edge.
  - i_go is ignored.
- DONE (exactly one cycle):
  - o_done=1, o_last_clk=1, o_clk_en=0, o_tip=0.
  - Next state is IDLE. i_go is ignored in DONE, so the earliest accepted restart is the cycle after DONE.
- o_rx_data holds its value until the next accepted go or reset. Bits above L-1 read 0.
- Latency: done pulse appears 1 cycle after the L-th RX edge pulse.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset mid-SHIFT after 3 bits of L=8 -> next cycle all outputs 0, state IDLE. Edge pulses afterwards do not move o_mosi. A following go works normally.
- L=8, MSB-first, tx=0xA5, MISO loopback (i_miso=o_mosi), tx on neg, rx on pos, 8 pos/neg pulse pairs -> MOSI sequence 1,0,1,0,0,1,0,1; o_rx_data=0x000000A5; o_done high exactly 1 cycle after the 8th pos pulse; o_tip low the same cycle.
- L=8, LSB-first, tx=0xA5, MISO tied to constant pattern 1,1,0,0,0,0,0,1 -> MOSI sequence 1,0,1,0,0,1,0,1; o_rx_data=0x83.
- i_len=0, MSB-first, tx=0x80000001, loopback -> 32 bits shifted; o_rx_data=0x80000001; exactly one o_done.
- Both edge selects = pos, L=4, tx=0x9, loopback -> same-pulse TX/RX handled; o_rx_data=0x9. Extra pos pulses after DONE are ignored.
- i_go held high continuously during a transfer -> ignored in SHIFT and DONE; new transfer starts the cycle after DONE. i_len/i_tx_data changed mid-transfer -> no effect on the current result.
